// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF       = 11;
    localparam int STARVE_LIMIT_DEF = 3;
    localparam int WORD_BYTES       = 4;

    typedef enum logic {
        PRI_LS = 1'b0,
        PRI_IF = 1'b1
    } pri_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_t;

    // Word alignment: low address bits inside a word must be zero.
    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb & 2'(WORD_BYTES - 1)) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_arb_rsp_slot.sv
// One-entry response register: loads on an accepted access, clears on consume,
// and reloads when a consume and a new access coincide.
module mem_arb_rsp_slot (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_consume,
    input  logic [31:0] i_rdata,
    input  logic        i_err,
    output logic        o_valid,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    logic        r_valid;
    logic [31:0] r_rdata;
    logic        r_err;

    // Response state; a load takes precedence over a consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_rdata <= 32'h0000_0000;
            r_err   <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_rdata <= i_rdata;
            r_err   <= i_err;
        end else if (r_valid && i_consume) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_rdata = r_rdata;
    assign o_err   = r_err;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and load/store ports onto a single-access memory,
// with starvation-protected priority and per-port registered responses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [31:0]       if_rsp_rdata,
    output logic              if_rsp_err,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic              ls_req_we,
    input  logic [3:0]        ls_req_be,
    input  logic [31:0]       ls_req_wdata,
    output logic              ls_rsp_valid,
    input  logic              ls_rsp_ready,
    output logic [31:0]       ls_rsp_rdata,
    output logic              ls_rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    pri_state_t       r_pri;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic w_if_elig, w_ls_elig;
    logic w_grant_if, w_grant_ls;
    logic w_if_aligned, w_ls_aligned;
    logic [31:0] w_if_rdata, w_ls_rdata;

    // A held response slot frees up in the same cycle it is consumed.
    assign w_if_elig = if_req_valid && (!if_rsp_valid || if_rsp_ready);
    assign w_ls_elig = ls_req_valid && (!ls_rsp_valid || ls_rsp_ready);

    assign w_grant_if = !rst && w_if_elig && ((r_pri == PRI_IF) || !w_ls_elig);
    assign w_grant_ls = !rst && w_ls_elig && ((r_pri == PRI_LS) || !w_if_elig);

    assign if_req_ready = w_grant_if;
    assign ls_req_ready = w_grant_ls;

    assign w_if_aligned = is_aligned(if_req_addr[1:0]);
    assign w_ls_aligned = is_aligned(ls_req_addr[1:0]);

    assign mem_addr  = w_grant_ls ? ls_req_addr : if_req_addr;
    assign mem_we    = w_grant_ls && ls_req_we && w_ls_aligned;
    assign mem_be    = w_grant_ls ? ls_req_be : 4'b0000;
    assign mem_wdata = w_grant_ls ? ls_req_wdata : 32'h0000_0000;

    assign w_if_rdata = w_if_aligned ? mem_rdata : 32'h0000_0000;
    assign w_ls_rdata = (w_ls_aligned && !ls_req_we) ? mem_rdata : 32'h0000_0000;

    // Next starvation count: cleared by an IF grant, saturating otherwise.
    always_comb begin
        w_cnt_nxt = r_starve_cnt;
        if (w_grant_if) begin
            w_cnt_nxt = '0;
        end else if (w_grant_ls && if_req_valid && (r_starve_cnt != LIMIT_C)) begin
            w_cnt_nxt = r_starve_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_nxt = r_starve_cnt;
        end
    end

    // Priority FSM; switching on the next count lets IF win right after the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pri        <= PRI_LS;
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_cnt_nxt;
            case (r_pri)
                PRI_LS:  if (w_cnt_nxt == LIMIT_C) r_pri <= PRI_IF;
                PRI_IF:  if (w_grant_if) r_pri <= PRI_LS;
                default: r_pri <= PRI_LS;
            endcase
        end
    end

    mem_arb_rsp_slot u_if_slot (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_grant_if),
        .i_consume (if_rsp_ready),
        .i_rdata   (w_if_rdata),
        .i_err     (!w_if_aligned),
        .o_valid   (if_rsp_valid),
        .o_rdata   (if_rsp_rdata),
        .o_err     (if_rsp_err)
    );

    mem_arb_rsp_slot u_ls_slot (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_grant_ls),
        .i_consume (ls_rsp_ready),
        .i_rdata   (w_ls_rdata),
        .i_err     (!w_ls_aligned),
        .o_valid   (ls_rsp_valid),
        .o_rdata   (ls_rsp_rdata),
        .o_err     (ls_rsp_err)
    );

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 2KB byte-addressable, word-aligned memory.
- The instruction-fetch (IF) port and the load/store (LS) port both need access; only one memory access happens per cycle.
- Drives the memory's address/write/byte-enable port, registers the read data, and returns a per-requester response through valid/ready handshakes.
- Sits between the pipeline's fetch/memory stages and the memory array.

Parameters:
- ADDR_W, 11, byte-address width (memory depth = 2**ADDR_W bytes).
- STARVE_LIMIT, 3, consecutive LS grants while IF waits before IF is forced priority.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_req_addr  in  ADDR_W  fetch byte address.
- if_rsp_valid  out  1  fetch response available.
- if_rsp_ready  in  1  fetch response consumed.
- if_rsp_rdata  out  32  fetched word.
- if_rsp_err  out  1  misaligned fetch.
- ls_req_valid  in  1  load/store request.
- ls_req_ready  out  1  load/store request accepted this cycle.
- ls_req_addr  in  ADDR_W  load/store byte address.
- ls_req_we  in  1  1 = store.
- ls_req_be  in  4  store byte enables; be[3] maps to addr+0.
- ls_req_wdata  in  32  store data; [31:24] maps to addr+0.
- ls_rsp_valid  out  1  load/store response available.
- ls_rsp_ready  in  1  load/store response consumed.
- ls_rsp_rdata  out  32  load data; 0 for stores.
- ls_rsp_err  out  1  misaligned access.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write strobe; the memory writes on posedge.
- mem_be  out  4  memory byte enables.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  combinational read data, big-endian {ram[a], ram[a+1], ram[a+2], ram[a+3]}.

Behaviour:
- Reset (async):
  - if_rsp_valid = ls_rsp_valid = 0; rdata = 0; err = 0.
  - starve_cnt = 0; pri_state = PRI_LS.
  - While rst is high: req_ready = 0, mem_we = 0.
- Eligibility: X is eligible when X_req_valid && (!X_rsp_valid || X_rsp_ready). A response slot freed in the same cycle allows back-to-back accesses.
- Grant: at most one per cycle; combinational from valids, eligibility and pri_state.
  - PRI_LS: LS wins if eligible, else IF.
  - PRI_IF: IF wins if eligible, else LS.
- X_req_ready = grant_X. A request is accepted when valid && ready. A requester must hold its request stable until ready.
- Accepted access:
  - mem_addr = granted address.
  - mem_we = ls_req_we && grant_LS && aligned.
  - mem_be / mem_wdata are taken from the LS port. For IF grants: be = 0, wdata = 0.
- Misaligned address (addr[1:0] != 0): no memory access (mem_we = 0); the response carries err = 1 and rdata = 0.
- Latency: request accepted at cycle N; X_rsp_valid = 1 at N+1.
  - Loads/fetches: rdata = mem_rdata sampled at N.
  - Stores: rdata = 0; the memory is updated at the N edge.
- Response hold: X_rsp_valid stays high with stable data until X_rsp_ready. It clears on consume unless a new access is accepted in the same cycle, in which case the slot reloads.
- Priority FSM and starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) when LS is granted while IF is valid.
  - starve_cnt clears when IF is granted.
  - PRI_LS -> PRI_IF when starve_cnt == STARVE_LIMIT.
  - PRI_IF -> PRI_LS after one IF grant.
- Store-then-load to the same word on consecutive accepts: the load returns the new data, since the write lands at the edge before the next read.
- Reset mid-response: pending responses are dropped; requesters must reissue.

Decomposition:
- Package mem_arb_pkg holds:
  - ADDR_W and STARVE_LIMIT defaults;
  - enum pri_state_t {PRI_LS, PRI_IF};
  - enum req_id_t {REQ_IF, REQ_LS};
  - WORD_BYTES = 4.
- Sub-module mem_arb_rsp_slot: the response register (valid/rdata/err with load, consume and reload-on-consume). Instantiated once per requester.

Test Plan:
- Memory bytes 0x000..0x003 = 11 22 33 44. IF fetch of addr 0x000 -> if_req_ready same cycle; next cycle if_rsp_valid = 1, rdata = 0x11223344, err = 0.
- LS store addr 0x010, be = 4'b0110, wdata = 0xAABBCCDD; then load 0x010 (bytes preloaded 0x00) -> ls_rsp_rdata = 0x00BBCC00 on the second response.
- IF and LS both valid continuously, if_rsp_ready = ls_rsp_ready = 1 -> grants LS, LS, LS, IF, LS, LS, LS, IF…; starve_cnt peaks at 3.
- LS load addr 0x013 -> mem_we = 0; ls_rsp_err = 1, rdata = 0.
- Hold if_rsp_ready = 0 for 4 cycles with if_req_valid = 1 -> if_req_ready = 0 throughout; rdata stable; LS is still granted in those cycles.
- Assert rst while ls_rsp_valid = 1 and a store is pending -> all rsp_valid = 0 immediately; no mem_we while reset is high; pri_state = PRI_LS after release.
